// File: rtl/core_pkg.sv
// Shared core types and constants for the register-file write path.
package core_pkg;

    localparam int XLEN      = 32;
    localparam int REG_COUNT = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } rf_wr_t;

    function automatic logic [5:0] popcount_busy(input logic [REG_COUNT-1:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < REG_COUNT; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rf_res_fifo.sv
// Small synchronous FIFO holding multicycle results until they win the write port.
module rf_res_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && (count_q != DEPTH_C);
    assign do_pop_s  = pop && (count_q != {CW{1'b0}});
    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-port scheduler for the 2R1W register file: arbitrates pipeline writeback
// against buffered multicycle results and keeps the busy scoreboard for decode.
module rf_wb_sched #(
    parameter int XLEN            = 32,
    parameter int BUF_DEPTH       = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipeline_en,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mc_issue_valid,
    input  logic [4:0]      mc_issue_rd,
    output logic            mc_issue_ready,
    input  logic            mc_res_valid,
    input  logic [4:0]      mc_res_rd,
    input  logic [XLEN-1:0] mc_res_data,
    output logic            mc_res_ready,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    input  logic [4:0]      dec_rd,
    input  logic            dec_use_rs1,
    input  logic            dec_use_rs2,
    input  logic            dec_use_rd,
    output logic            hazard,
    output logic            wb_hold,
    output logic            rf_en,
    output logic            rf_wen,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            err_spurious
);

    import core_pkg::*;

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int AW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(BUF_DEPTH);
    localparam logic [AW-1:0] STARVE_C  = AW'(STARVE_LIMIT);
    localparam logic [5:0]    MAX_OUT_C = 6'(MAX_OUTSTANDING);

    logic [REG_COUNT-1:0] busy_q, busy_d, busy_fwd_s;
    logic [AW-1:0]        age_q, age_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        count_s;
    rf_wr_t               head_s, push_data_s;
    logic                 push_s, pop_s, issue_fire_s, hold_s;
    logic [5:0]           outstanding_s;

    assign push_data_s = '{rd: mc_res_rd, data: mc_res_data};

    rf_res_fifo #(
        .WIDTH ($bits(rf_wr_t)),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    // Write-port arbitration: forced drain, then pipeline, then opportunistic drain.
    always_comb begin
        hold_s   = (count_s != {CW{1'b0}}) && ((count_s == DEPTH_C) || (age_q >= STARVE_C));
        pop_s    = 1'b0;
        rf_wen   = 1'b0;
        rf_rd    = 5'd0;
        rf_wdata = {XLEN{1'b0}};
        rf_en    = pipeline_en;
        if (hold_s) begin
            pop_s    = 1'b1;
            rf_wen   = 1'b1;
            rf_rd    = head_s.rd;
            rf_wdata = head_s.data;
            rf_en    = 1'b1;
        end else if (pipeline_en && wb_valid) begin
            rf_wen   = 1'b1;
            rf_rd    = wb_rd;
            rf_wdata = wb_data;
            rf_en    = 1'b1;
        end else if (count_s != {CW{1'b0}}) begin
            pop_s    = 1'b1;
            rf_wen   = 1'b1;
            rf_rd    = head_s.rd;
            rf_wdata = head_s.data;
            rf_en    = 1'b1;
        end else begin
            rf_wen   = 1'b0;
            rf_en    = pipeline_en;
        end
    end

    // Decode sees the popped register as free: the reg_file bypass supplies its value.
    always_comb begin
        busy_fwd_s = busy_q;
        if (pop_s) begin
            busy_fwd_s[head_s.rd] = 1'b0;
        end else begin
            busy_fwd_s = busy_q;
        end
        hazard = (dec_use_rs1 && busy_fwd_s[dec_rs1]) ||
                 (dec_use_rs2 && busy_fwd_s[dec_rs2]) ||
                 (dec_use_rd  && busy_fwd_s[dec_rd])  ||
                 hold_s;
        wb_hold = hold_s;
    end

    // Handshakes look at registered busy only, so a register freed this cycle waits one.
    always_comb begin
        outstanding_s  = popcount_busy(busy_q);
        mc_issue_ready = !rst && !busy_q[mc_issue_rd] && (outstanding_s < MAX_OUT_C) &&
                         pipeline_en && !hold_s;
        mc_res_ready   = !rst && (count_s < DEPTH_C);
        issue_fire_s   = mc_issue_valid && mc_issue_ready;
        push_s         = mc_res_valid && mc_res_ready;
    end

    // Next-state for scoreboard, starvation age and sticky error.
    always_comb begin
        busy_d = busy_fwd_s;
        if (issue_fire_s && (mc_issue_rd != 5'd0)) begin
            busy_d[mc_issue_rd] = 1'b1;
        end else begin
            busy_d = busy_fwd_s;
        end
        busy_d[0] = 1'b0;
        err_d = err_q || (push_s && (mc_res_rd != 5'd0) && !busy_q[mc_res_rd]);
        if ((count_s == {CW{1'b0}}) || pop_s) begin
            age_d = {AW{1'b0}};
        end else if (age_q < STARVE_C) begin
            age_d = age_q + AW'(1);
        end else begin
            age_d = age_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= {REG_COUNT{1'b0}};
            age_q  <= {AW{1'b0}};
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
            err_q  <= err_d;
        end
    end

    assign err_spurious = err_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_rf_wb_sched;

    logic        clk = 1'b0;
    logic        rst, pipeline_en, wb_valid, mc_issue_valid, mc_res_valid;
    logic [4:0]  wb_rd, mc_issue_rd, mc_res_rd, dec_rs1, dec_rs2, dec_rd;
    logic [31:0] wb_data, mc_res_data;
    logic        dec_use_rs1, dec_use_rs2, dec_use_rd;
    logic        mc_issue_ready, mc_res_ready, hazard, wb_hold, rf_en, rf_wen, err_spurious;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit [31:0]   m_busy;
    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    int          m_age;
    bit          m_err;
    bit          e_hold, e_pop, e_wen, e_en, e_haz, e_iready, e_rready;
    logic [4:0]  e_rd;
    logic [31:0] e_data;

    always #5 clk = ~clk;

    rf_wb_sched dut (
        .clk(clk), .rst(rst), .pipeline_en(pipeline_en),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mc_issue_valid(mc_issue_valid), .mc_issue_rd(mc_issue_rd), .mc_issue_ready(mc_issue_ready),
        .mc_res_valid(mc_res_valid), .mc_res_rd(mc_res_rd), .mc_res_data(mc_res_data),
        .mc_res_ready(mc_res_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_use_rd(dec_use_rd),
        .hazard(hazard), .wb_hold(wb_hold), .rf_en(rf_en), .rf_wen(rf_wen),
        .rf_rd(rf_rd), .rf_wdata(rf_wdata), .err_spurious(err_spurious)
    );

    function automatic void predict();
        int cnt;
        bit pipe;
        bit [31:0] bp;
        cnt      = q_rd.size();
        e_hold   = (cnt > 0) && (cnt == 2 || m_age >= 4);
        pipe     = !e_hold && pipeline_en && wb_valid;
        e_pop    = e_hold || (cnt > 0 && !(pipeline_en && wb_valid));
        e_wen    = e_pop || pipe;
        e_en     = e_pop || pipeline_en;
        e_rd     = e_pop ? q_rd[0] : wb_rd;
        e_data   = e_pop ? q_data[0] : wb_data;
        bp       = m_busy;
        if (e_pop) bp[q_rd[0]] = 1'b0;
        e_haz    = (dec_use_rs1 && bp[dec_rs1]) || (dec_use_rs2 && bp[dec_rs2]) ||
                   (dec_use_rd && bp[dec_rd]) || e_hold;
        e_iready = !rst && !m_busy[mc_issue_rd] && ($countones(m_busy) < 4) &&
                   pipeline_en && !e_hold;
        e_rready = !rst && (cnt < 2);
    endfunction

    // Advance one clock and update the model with the inputs seen at that edge.
    task automatic tick();
        bit spur;
        predict();
        @(posedge clk);
        if (rst) begin
            m_busy = 32'd0;
            q_rd.delete();
            q_data.delete();
            m_age  = 0;
            m_err  = 1'b0;
        end else begin
            spur = mc_res_valid && e_rready && (mc_res_rd != 5'd0) && !m_busy[mc_res_rd];
            if (e_pop) begin
                m_age = 0;
                m_busy[q_rd[0]] = 1'b0;
                void'(q_rd.pop_front());
                void'(q_data.pop_front());
            end else if (q_rd.size() > 0) begin
                if (m_age < 4) m_age++;
            end else begin
                m_age = 0;
            end
            if (mc_issue_valid && e_iready && mc_issue_rd != 5'd0) m_busy[mc_issue_rd] = 1'b1;
            if (mc_res_valid && e_rready) begin
                q_rd.push_back(mc_res_rd);
                q_data.push_back(mc_res_data);
            end
            if (spur) m_err = 1'b1;
            m_busy[0] = 1'b0;
        end
        #1;
    endtask

    task automatic clear_inputs();
        pipeline_en = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        mc_issue_valid = 1'b0; mc_issue_rd = 5'd0;
        mc_res_valid = 1'b0; mc_res_rd = 5'd0; mc_res_data = 32'd0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
        dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_use_rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        n_tests++; if (mc_res_ready !== 1'b0) begin n_fail++; $display("FAIL rst_res_ready got %b want 0", mc_res_ready); end
        n_tests++; if (mc_issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_issue_ready got %b want 0", mc_issue_ready); end
        tick();
        rst = 1'b0;
        #2;
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %b want 0", hazard); end
        n_tests++; if (wb_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold got %b want 0", wb_hold); end
        n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b want 0", rf_wen); end
        n_tests++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_spurious); end
        n_tests++; if (mc_res_ready !== 1'b1) begin n_fail++; $display("FAIL reset_res_ready got %b want 1", mc_res_ready); end
        n_tests++; if (mc_issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got %b want 1", mc_issue_ready); end
    endtask

    task automatic test_raw();
        clear_inputs();
        mc_issue_valid = 1'b1; mc_issue_rd = 5'd5;
        #2;
        n_tests++; if (mc_issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_issue got %b want 1", mc_issue_ready); end
        tick();
        mc_issue_valid = 1'b0; dec_rs1 = 5'd5; dec_use_rs1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL raw_hazard_wait got %b want 1", hazard); end
            tick();
        end
        mc_res_valid = 1'b1; mc_res_rd = 5'd5; mc_res_data = 32'h1234_5678;
        #2;
        n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL raw_hazard_accept got %b want 1", hazard); end
        tick();
        mc_res_valid = 1'b0;
        #2;
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL raw_hazard_pop got %b want 0", hazard); end
        n_tests++; if (rf_wen !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL raw_write got wen=%b rd=%0d data=%h want 1/5/12345678", rf_wen, rf_rd, rf_wdata); end
        tick();
        #2;
        n_tests++; if (hazard !== 1'b0 || mc_issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL raw_freed got hazard=%b ready=%b want 0/1", hazard, mc_issue_ready); end
    endtask

    task automatic test_starve();
        clear_inputs();
        mc_issue_valid = 1'b1; mc_issue_rd = 5'd7;
        tick();
        mc_issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0333;
        mc_res_valid = 1'b1; mc_res_rd = 5'd7; mc_res_data = 32'h0000_DEAD;
        tick();
        mc_res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_tests++; if (wb_hold !== 1'b0 || rf_rd !== 5'd3) begin
                n_fail++; $display("FAIL starve_wait%0d got hold=%b rd=%0d want 0/3", i, wb_hold, rf_rd); end
            tick();
        end
        #2;
        n_tests++; if (wb_hold !== 1'b1 || rf_wen !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h0000_DEAD || rf_en !== 1'b1) begin
            n_fail++; $display("FAIL starve_drain got hold=%b wen=%b rd=%0d data=%h en=%b want 1/1/7/dead/1",
                               wb_hold, rf_wen, rf_rd, rf_wdata, rf_en); end
        n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL starve_hazard got %b want 1", hazard); end
        tick();
        #2;
        n_tests++; if (wb_hold !== 1'b0 || rf_rd !== 5'd3) begin
            n_fail++; $display("FAIL starve_after got hold=%b rd=%0d want 0/3", wb_hold, rf_rd); end
    endtask

    task automatic test_full();
        clear_inputs();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0333;
        mc_issue_valid = 1'b1; mc_issue_rd = 5'd10; tick();
        mc_issue_rd = 5'd11; tick();
        mc_issue_valid = 1'b0;
        mc_res_valid = 1'b1; mc_res_rd = 5'd10; mc_res_data = 32'hAAAA_0010; tick();
        mc_res_rd = 5'd11; mc_res_data = 32'hBBBB_0011; tick();
        mc_res_valid = 1'b0;
        #2;
        n_tests++; if (mc_res_ready !== 1'b0 || wb_hold !== 1'b1) begin
            n_fail++; $display("FAIL full_flags got ready=%b hold=%b want 0/1", mc_res_ready, wb_hold); end
        n_tests++; if (rf_rd !== 5'd10 || rf_wdata !== 32'hAAAA_0010) begin
            n_fail++; $display("FAIL full_pop1 got rd=%0d data=%h want 10/aaaa0010", rf_rd, rf_wdata); end
        tick();
        wb_valid = 1'b0;
        #2;
        n_tests++; if (rf_wen !== 1'b1 || rf_rd !== 5'd11 || rf_wdata !== 32'hBBBB_0011) begin
            n_fail++; $display("FAIL full_pop2 got wen=%b rd=%0d data=%h want 1/11/bbbb0011", rf_wen, rf_rd, rf_wdata); end
        tick();
        #2;
        n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL full_empty got wen=%b want 0", rf_wen); end
    endtask

    task automatic test_outstanding();
        do_reset();
        clear_inputs();
        mc_issue_valid = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            mc_issue_rd = 5'(r);
            #2;
            n_tests++; if (mc_issue_ready !== 1'b1) begin n_fail++; $display("FAIL out_issue%0d got %b want 1", r, mc_issue_ready); end
            tick();
        end
        mc_issue_rd = 5'd5;
        #2;
        n_tests++; if (mc_issue_ready !== 1'b0) begin n_fail++; $display("FAIL out_fifth got %b want 0", mc_issue_ready); end
        mc_issue_rd = 5'd3;
        #2;
        n_tests++; if (mc_issue_ready !== 1'b0) begin n_fail++; $display("FAIL out_reissue got %b want 0", mc_issue_ready); end
        mc_issue_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_spurious();
        do_reset();
        clear_inputs();
        mc_res_valid = 1'b1; mc_res_rd = 5'd9; mc_res_data = 32'h0000_0009;
        #2;
        n_tests++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL spur_before got %b want 0", err_spurious); end
        tick();
        mc_res_valid = 1'b0;
        #2;
        n_tests++; if (err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_set got %b want 1", err_spurious); end
        n_tests++; if (rf_wen !== 1'b1 || rf_rd !== 5'd9) begin
            n_fail++; $display("FAIL spur_written got wen=%b rd=%0d want 1/9", rf_wen, rf_rd); end
        repeat (3) tick();
        #2;
        n_tests++; if (err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_sticky got %b want 1", err_spurious); end
        do_reset();
        #2;
        n_tests++; if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL spur_cleared got %b want 0", err_spurious); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_inputs();
        wb_valid = 1'b1; wb_rd = 5'd3;
        mc_issue_valid = 1'b1; mc_issue_rd = 5'd1; tick();
        mc_issue_rd = 5'd2; tick();
        mc_issue_valid = 1'b0;
        mc_res_valid = 1'b1; mc_res_rd = 5'd1; mc_res_data = 32'h0000_0101; tick();
        mc_res_rd = 5'd2; mc_res_data = 32'h0000_0202; tick();
        mc_res_valid = 1'b0;
        #2;
        n_tests++; if (wb_hold !== 1'b1) begin n_fail++; $display("FAIL mid_full got hold=%b want 1", wb_hold); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb_valid = 1'b0;
        dec_rs1 = 5'd1; dec_use_rs1 = 1'b1; dec_rs2 = 5'd2; dec_use_rs2 = 1'b1;
        mc_issue_rd = 5'd1;
        #2;
        n_tests++; if (wb_hold !== 1'b0 || hazard !== 1'b0 || rf_wen !== 1'b0 || err_spurious !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got hold=%b haz=%b wen=%b err=%b want 0/0/0/0",
                               wb_hold, hazard, rf_wen, err_spurious); end
        n_tests++; if (mc_issue_ready !== 1'b1 || mc_res_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_ready got issue=%b res=%b want 1/1", mc_issue_ready, mc_res_ready); end
        tick();
        #2;
        n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL mid_drained got wen=%b want 0", rf_wen); end
    endtask

    task automatic test_random();
        int cand[$];
        do_reset();
        clear_inputs();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst         = ($urandom_range(0, 99) == 0);
            pipeline_en = ($urandom_range(0, 7) != 0);
            wb_valid    = $urandom_range(0, 1);
            wb_rd       = 5'($urandom_range(0, 31));
            wb_data     = $urandom;
            dec_rs1 = 5'($urandom_range(0, 31)); dec_use_rs1 = $urandom_range(0, 1);
            dec_rs2 = 5'($urandom_range(0, 31)); dec_use_rs2 = $urandom_range(0, 1);
            dec_rd  = 5'($urandom_range(0, 31)); dec_use_rd  = $urandom_range(0, 1);
            mc_issue_valid = $urandom_range(0, 1);
            mc_issue_rd    = 5'($urandom_range(0, 9));
            cand.delete();
            for (int r = 1; r < 32; r++) begin
                if (m_busy[r] && !(r inside {q_rd})) cand.push_back(r);
            end
            mc_res_valid = ($urandom_range(0, 9) < 4);
            if (cand.size() > 0 && $urandom_range(0, 19) != 0)
                mc_res_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            else
                mc_res_rd = 5'($urandom_range(0, 31));
            mc_res_data = $urandom;
            #2;
            predict();
            n_tests++; if (wb_hold !== e_hold) begin n_fail++; $display("FAIL rnd_hold cyc%0d got %b want %b", cyc, wb_hold, e_hold); end
            n_tests++; if (hazard !== e_haz) begin n_fail++; $display("FAIL rnd_hazard cyc%0d got %b want %b", cyc, hazard, e_haz); end
            n_tests++; if (rf_wen !== e_wen || rf_en !== e_en) begin
                n_fail++; $display("FAIL rnd_wen cyc%0d got wen=%b en=%b want %b/%b", cyc, rf_wen, rf_en, e_wen, e_en); end
            if (e_wen) begin
                n_tests++; if (rf_rd !== e_rd || rf_wdata !== e_data) begin
                    n_fail++; $display("FAIL rnd_wdata cyc%0d got rd=%0d data=%h want %0d/%h", cyc, rf_rd, rf_wdata, e_rd, e_data); end
            end
            n_tests++; if (mc_issue_ready !== e_iready) begin
                n_fail++; $display("FAIL rnd_issue_ready cyc%0d got %b want %b", cyc, mc_issue_ready, e_iready); end
            n_tests++; if (mc_res_ready !== e_rready) begin
                n_fail++; $display("FAIL rnd_res_ready cyc%0d got %b want %b", cyc, mc_res_ready, e_rready); end
            n_tests++; if (err_spurious !== m_err) begin
                n_fail++; $display("FAIL rnd_err cyc%0d got %b want %b", cyc, err_spurious, m_err); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        m_busy = 32'd0; m_age = 0; m_err = 1'b0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_raw();
        test_starve();
        test_full();
        test_outstanding();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
